mem_loader: RTL

- Boot-time loader sitting directly upstream of the 6502 test memory: it owns the memory's address/data/control inputs until a program image has been streamed in, then hands the bus to the CPU.
- Accepts bytes over a valid/ready stream (e.g. from a UART receiver) and writes them to consecutive addresses starting at START_ADDR.
- Holds the CPU in reset until the load completes plus a hold interval.

---
 rtl/mem_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - boot loader that streams an image into the 6502 test memory, then releases the CPU
// Optional MEM_LOADER_CHECKSUM_EN: drives checksum with the 8-bit sum of all accepted bytes.
module mem_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int LOAD_BYTES = 512,
    parameter int START_ADDR = 0,
    parameter int RESET_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_bypass,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_AB,
    input  logic                  cpu_WE,
    input  logic                  cpu_CS,
    input  logic [7:0]            cpu_DO,
    output logic [ADDR_WIDTH-1:0] mem_AB,
    output logic                  mem_WE,
    output logic                  mem_CS,
    output logic [7:0]            mem_DI,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic [7:0]            checksum
);
    localparam int                    CNT_W     = $clog2(LOAD_BYTES + 1);
    localparam logic [ADDR_WIDTH-1:0] START     = ADDR_WIDTH'(START_ADDR);
    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(LOAD_BYTES - 1);
    localparam logic [7:0]            HOLD_LAST = 8'(RESET_HOLD - 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      byte_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            hold_cnt;
    logic [ADDR_WIDTH-1:0] wr_ab;
    logic [7:0]            wr_di;
    logic                  wr_we;
    logic                  accept;

    always_comb begin
        state_d  = state;
        rx_ready = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: state_d = load_bypass ? HOLD : LOAD;
            LOAD: begin
                rx_ready = 1'b1;
                accept   = rx_valid;
                if (rx_valid && (byte_cnt == LAST_BYTE)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // The final write is still on the bus in the first HOLD cycle; the hold interval starts after it commits.
                if (!wr_we && (hold_cnt == HOLD_LAST)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            addr_q   <= START;
            hold_cnt <= '0;
            wr_ab    <= START;
            wr_di    <= '0;
            wr_we    <= 1'b0;
        end else begin
            state <= state_d;
            wr_we <= accept;
            if (accept) begin
                wr_ab    <= addr_q;
                wr_di    <= rx_data;
                addr_q   <= addr_q + 1'b1;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (state == HOLD && !wr_we) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign cpu_reset = (state != RUN);
    assign load_done = (state == RUN);

    // While the loader owns the bus, non-write cycles are harmless reads (WE=0, CS=1).
    assign mem_AB = load_done ? cpu_AB : wr_ab;
    assign mem_WE = load_done ? cpu_WE : wr_we;
    assign mem_CS = load_done ? cpu_CS : 1'b1;
    assign mem_DI = load_done ? cpu_DO : wr_di;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + rx_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
